// File: rtl/punc_mem_arbiter.sv
// Single-port memory arbiter for PUnC: fetch, data and debug share one synchronous-read memory.
// Define PUNC_ARB_AGING_EN to let a starved debug request force its way past data and fetch.
module punc_mem_arbiter #(
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 16,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_lock,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    input  logic          x_req,
    input  logic          x_we,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_wdata,
    output logic          x_gnt,
    output logic          x_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {IDLE, LOCKED} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_F, TAG_D, TAG_X} tag_t;

    state_t state, state_next;
    tag_t   tag, tag_next;
    logic   aged;

`ifdef PUNC_ARB_AGING_EN
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] age;

    always_ff @(posedge clk) begin
        if (rst || !x_req || x_gnt)
            age <= '0;
        else if (age != CW'(STARVE_LIMIT))
            age <= age + 1'b1;
    end

    assign aged = (age == CW'(STARVE_LIMIT));
`else
    assign aged = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tag   <= TAG_NONE;
        end else begin
            state <= state_next;
            tag   <= tag_next;
        end
    end

    always_comb begin
        f_gnt      = 1'b0;
        d_gnt      = 1'b0;
        x_gnt      = 1'b0;
        state_next = state;
        if (!rst) begin
            if (state == LOCKED)
                d_gnt = d_req;
            else if (aged && x_req)
                x_gnt = 1'b1;
            else if (d_req)
                d_gnt = 1'b1;
            else if (f_req)
                f_gnt = 1'b1;
            else if (x_req)
                x_gnt = 1'b1;
        end
        // A lock-holder that stops requesting without asserting d_lock also releases.
        if (d_gnt)
            state_next = d_lock ? LOCKED : IDLE;
        else if (state == LOCKED && !d_req && !d_lock)
            state_next = IDLE;
    end

    always_comb begin
        tag_next = TAG_NONE;
        if (d_gnt && !d_we)
            tag_next = TAG_D;
        else if (f_gnt)
            tag_next = TAG_F;
        else if (x_gnt && !x_we)
            tag_next = TAG_X;
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (x_gnt) begin
            mem_addr  = x_addr;
            mem_wdata = x_wdata;
        end else if (f_gnt) begin
            mem_addr  = f_addr;
        end
    end

    assign mem_en = f_gnt | d_gnt | x_gnt;
    assign mem_we = (d_gnt & d_we) | (x_gnt & x_we);
    assign rdata  = mem_rdata;

    // Gated by rst so a read interrupted by reset never reports valid data.
    assign f_rvalid = (tag == TAG_F) && !rst;
    assign d_rvalid = (tag == TAG_D) && !rst;
    assign x_rvalid = (tag == TAG_X) && !rst;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Directed bench for punc_mem_arbiter with a synchronous-read memory model.
// Aging expectations follow PUNC_ARB_AGING_EN.
module tb_punc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_we, d_lock, x_req, x_we;
  logic [15:0] f_addr, d_addr, d_wdata, x_addr, x_wdata;
  logic        f_gnt, f_rvalid, d_gnt, d_rvalid, x_gnt, x_rvalid;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;

  logic [15:0] mem [0:65535];
  int checks = 0;
  int failures = 0;
  int first_gnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        mem[mem_addr] <= mem_wdata;
      else
        mem_rdata <= mem[mem_addr];
    end
  end

  punc_mem_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    mem[16'h3000] = 16'h1234;
    mem[16'h3001] = 16'h4000;
    mem[16'h4000] = 16'h7777;
    mem[16'h0100] = 16'hAAAA;
    mem[16'h0200] = 16'h2222;
    mem[16'h0010] = 16'h5555;
    mem[16'h0011] = 16'h3333;
    mem_rdata = '0;

    rst = 1'b1;
    f_req = 1'b1; f_addr = 16'h0100;
    d_req = 1'b1; d_we = 1'b0; d_lock = 1'b0; d_addr = 16'h3000; d_wdata = '0;
    x_req = 1'b1; x_we = 1'b0; x_addr = 16'h0010; x_wdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_gnt", {f_gnt, d_gnt, x_gnt}, 3'b000);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b000);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("a_gnt", {f_gnt, d_gnt, x_gnt}, 3'b010);
    check("a_mem_addr", mem_addr, 16'h3000);
    check("a_mem_we", mem_we, 1'b0);

    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("b_gnt", {f_gnt, d_gnt, x_gnt}, 3'b100);
    check("b_rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b010);
    check("b_rdata", rdata, 16'h1234);

    @(posedge clk); #1;
    f_req = 1'b0;
    @(negedge clk);
    check("c_gnt", {f_gnt, d_gnt, x_gnt}, 3'b001);
    check("c_rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b100);
    check("c_rdata", rdata, 16'hAAAA);

    @(posedge clk); #1;
    x_req = 1'b0;
    @(negedge clk);
    check("d_rvalid_x", {f_rvalid, d_rvalid, x_rvalid}, 3'b001);
    check("d_rdata", rdata, 16'h5555);
    check("d_idle_bus", {mem_en, mem_addr, mem_wdata}, 33'h0);

    @(posedge clk); #1;
    d_req = 1'b1; d_lock = 1'b1; d_addr = 16'h3001;
    f_req = 1'b1; f_addr = 16'h0200;
    x_req = 1'b1; x_addr = 16'h0011;
    @(negedge clk);
    check("e_gnt", {f_gnt, d_gnt, x_gnt}, 3'b010);

    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("f_locked_gnt", {f_gnt, d_gnt, x_gnt}, 3'b000);
    check("f_locked_mem_en", mem_en, 1'b0);
    check("f_rdata", {d_rvalid, rdata}, 17'h1_4000);

    @(posedge clk); #1;
    d_req = 1'b1; d_lock = 1'b0; d_addr = 16'h4000;
    @(negedge clk);
    check("g_gnt", {f_gnt, d_gnt, x_gnt}, 3'b010);
    check("g_mem_addr", mem_addr, 16'h4000);

    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("h_gnt", {f_gnt, d_gnt, x_gnt}, 3'b100);
    check("h_rdata", {d_rvalid, rdata}, 17'h1_7777);

    @(posedge clk); #1;
    f_req = 1'b0;
    @(negedge clk);
    check("i_gnt", {f_gnt, d_gnt, x_gnt}, 3'b001);
    check("i_rdata", {f_rvalid, rdata}, 17'h1_2222);

    @(posedge clk); #1;
    x_req = 1'b0;
    @(negedge clk);
    check("j_rdata", {x_rvalid, rdata}, 17'h1_3333);

    @(posedge clk); #1;
    x_req = 1'b1; x_we = 1'b1; x_addr = 16'h0010; x_wdata = 16'hBEEF;
    @(negedge clk);
    check("k_gnt", {f_gnt, d_gnt, x_gnt}, 3'b001);
    check("k_mem_we", mem_we, 1'b1);
    check("k_mem_bus", {mem_addr, mem_wdata}, 32'h0010_BEEF);

    @(posedge clk); #1;
    x_req = 1'b0; x_we = 1'b0; x_wdata = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    @(negedge clk);
    check("l_no_rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b000);
    check("l_gnt", {f_gnt, d_gnt, x_gnt}, 3'b010);

    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("m_readback", {d_rvalid, x_rvalid, rdata}, 18'h2_BEEF);

    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 16'h0100;
    x_req = 1'b1; x_addr = 16'h0010;
    first_gnt = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (x_gnt && first_gnt < 0)
        first_gnt = i;
      @(posedge clk); #1;
    end
`ifdef PUNC_ARB_AGING_EN
    check("aging_first_gnt", first_gnt, 8);
`else
    check("aging_first_gnt", first_gnt, -1);
`endif

    f_req = 1'b0; x_req = 1'b0;
    d_req = 1'b1; d_addr = 16'h3000;
    @(negedge clk);
    check("p_gnt", {f_gnt, d_gnt, x_gnt}, 3'b010);

    @(posedge clk); #1;
    d_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("q_rst_rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b000);
    check("q_rst_mem_en", mem_en, 1'b0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("r_post_rst_rvalid", {f_rvalid, d_rvalid, x_rvalid}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
